// File: rtl/sum_group_pkg.sv
// sum_group_pkg: shared state encoding and width helper for the sum group accumulator.
package sum_group_pkg;
    typedef enum logic [0:0] { ACCUM, HOLD } sum_group_state_t;

    function automatic int calc_out_width(input int in_width, input int n_items);
        return in_width + $clog2(n_items);
    endfunction
endpackage

// File: rtl/group_item_counter.sv
// group_item_counter: counts items within a group and flags the group's final item.
module group_item_counter #(
    parameter int n_items = 4,
    localparam int cw = $clog2(n_items) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic restart,
    input  logic clr,
    input  logic last,
    output logic last_item
);
    logic [cw-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (restart) cnt <= cw'(1);
        else if (inc) cnt <= cnt + cw'(1);
    end

    assign last_item = (cnt == cw'(n_items - 1)) | last;
endmodule

// File: rtl/sum_group_accumulator.sv
// sum_group_accumulator: sums groups of n_items input sums and emits one total per group.
// Optional SUM_GROUP_EARLY_LAST_EN adds up_last to close a group early.
module sum_group_accumulator
    import sum_group_pkg::*;
#(
    parameter int in_width  = 9,
    parameter int n_items   = 4,
    parameter int out_width = calc_out_width(in_width, n_items)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up_vld,
    output logic                 up_rdy,
    input  logic [in_width-1:0]  up_data,
`ifdef SUM_GROUP_EARLY_LAST_EN
    input  logic                 up_last,
`endif
    output logic                 down_vld,
    input  logic                 down_rdy,
    output logic [out_width-1:0] down_data
);
    sum_group_state_t state, next_state;
    logic [out_width-1:0] acc, out_q, sum;
    logic xfer_in, xfer_out, last_item, last, inc, restart, clr;

`ifdef SUM_GROUP_EARLY_LAST_EN
    assign last = up_last;
`else
    assign last = 1'b0;
`endif

    // acc is always zero in HOLD, so sum is just up_data when a new group starts there
    assign sum = acc + out_width'(up_data);

    group_item_counter #(.n_items(n_items)) u_cnt (
        .clk(clk),
        .rst(rst),
        .inc(inc),
        .restart(restart),
        .clr(clr),
        .last(last),
        .last_item(last_item)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else state <= next_state;
    end

    always_comb begin
        up_rdy     = ~rst & ((state == ACCUM) | down_rdy);
        down_vld   = state == HOLD;
        xfer_in    = up_vld & up_rdy;
        xfer_out   = down_vld & down_rdy;
        clr        = xfer_in & last_item;
        inc        = xfer_in & ~last_item & (state == ACCUM);
        restart    = xfer_in & ~last_item & (state == HOLD);
        next_state = clr ? HOLD : xfer_out ? ACCUM : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            out_q <= '0;
        end else if (xfer_in) begin
            acc <= last_item ? '0 : sum;
            if (last_item) out_q <= sum;
        end
    end

    assign down_data = out_q;
endmodule

// File: tb/tb_sum_group_accumulator.sv
// tb_sum_group_accumulator: directed tests of grouping, backpressure and reset for the accumulator.
module tb_sum_group_accumulator;
    logic        clk = 0;
    logic        rst = 1;
    logic        up_vld = 0;
    logic        up_rdy;
    logic [8:0]  up_data = '0;
    logic        up_last = 0;
    logic        down_vld;
    logic        down_rdy = 1;
    logic [10:0] down_data;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    sum_group_accumulator dut (
        .clk(clk),
        .rst(rst),
        .up_vld(up_vld),
        .up_rdy(up_rdy),
        .up_data(up_data),
`ifdef SUM_GROUP_EARLY_LAST_EN
        .up_last(up_last),
`endif
        .down_vld(down_vld),
        .down_rdy(down_rdy),
        .down_data(down_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (up_rdy !== 1'b0) $display("FAIL reset_up_rdy got %0d want 0", up_rdy);
        else passed++;
        total++;
        if (down_vld !== 1'b0) $display("FAIL reset_down_vld got %0d want 0", down_vld);
        else passed++;
        total++;
        if (down_data !== 11'd0) $display("FAIL reset_down_data got %0d want 0", down_data);
        else passed++;
        @(negedge clk);
        rst = 0;
        #1;
        total++;
        if (up_rdy !== 1'b1) $display("FAIL release_up_rdy got %0d want 1", up_rdy);
        else passed++;
    endtask

    task automatic test_basic();
        down_rdy = 1;
        for (int i = 1; i <= 4; i++) begin
            up_vld = 1;
            up_data = 9'(i);
            total++;
            if (down_vld !== 1'b0) $display("FAIL basic_idle_vld item %0d got %0d want 0", i, down_vld);
            else passed++;
            step();
        end
        up_vld = 0;
        total++;
        if (down_vld !== 1'b1 || down_data !== 11'd10)
            $display("FAIL basic_total got vld=%0d data=%0d want vld=1 data=10", down_vld, down_data);
        else passed++;
        step();
        total++;
        if (down_vld !== 1'b0) $display("FAIL basic_drain got %0d want 0", down_vld);
        else passed++;
    endtask

    task automatic test_max();
        down_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            up_vld = 1;
            up_data = 9'd511;
            step();
        end
        up_vld = 0;
        total++;
        if (down_vld !== 1'b1 || down_data !== 11'd2044)
            $display("FAIL max_total got vld=%0d data=%0d want vld=1 data=2044", down_vld, down_data);
        else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        down_rdy = 1;
        for (int i = 1; i <= 8; i++) begin
            up_vld = 1;
            up_data = 9'(i);
            total++;
            if (up_rdy !== 1'b1) $display("FAIL b2b_up_rdy item %0d got %0d want 1", i, up_rdy);
            else passed++;
            step();
            if (i == 4) begin
                total++;
                if (down_vld !== 1'b1 || down_data !== 11'd10)
                    $display("FAIL b2b_first got vld=%0d data=%0d want vld=1 data=10", down_vld, down_data);
                else passed++;
            end
            if (i == 5) begin
                total++;
                if (down_vld !== 1'b0) $display("FAIL b2b_gap got %0d want 0", down_vld);
                else passed++;
            end
        end
        up_vld = 0;
        total++;
        if (down_vld !== 1'b1 || down_data !== 11'd26)
            $display("FAIL b2b_second got vld=%0d data=%0d want vld=1 data=26", down_vld, down_data);
        else passed++;
        step();
    endtask

    task automatic test_backpressure();
        down_rdy = 0;
        for (int i = 1; i <= 4; i++) begin
            up_vld = 1;
            up_data = 9'(i);
            step();
        end
        up_data = 9'd5;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (up_rdy !== 1'b0 || down_vld !== 1'b1 || down_data !== 11'd10)
                $display("FAIL bp_hold cyc %0d got rdy=%0d vld=%0d data=%0d want rdy=0 vld=1 data=10",
                         c, up_rdy, down_vld, down_data);
            else passed++;
            step();
        end
        down_rdy = 1;
        #1;
        total++;
        if (up_rdy !== 1'b1) $display("FAIL bp_rdy_follow got %0d want 1", up_rdy);
        else passed++;
        step();
        total++;
        if (down_vld !== 1'b0) $display("FAIL bp_release_vld got %0d want 0", down_vld);
        else passed++;
        for (int i = 6; i <= 8; i++) begin
            up_data = 9'(i);
            step();
        end
        up_vld = 0;
        total++;
        if (down_vld !== 1'b1 || down_data !== 11'd26)
            $display("FAIL bp_next_group got vld=%0d data=%0d want vld=1 data=26", down_vld, down_data);
        else passed++;
        step();
    endtask

    task automatic test_async_reset();
        down_rdy = 1;
        for (int i = 0; i < 2; i++) begin
            up_vld = 1;
            up_data = 9'd7;
            step();
        end
        up_vld = 0;
        #2;
        rst = 1;
        #1;
        total++;
        if (up_rdy !== 1'b0 || down_vld !== 1'b0 || down_data !== 11'd0)
            $display("FAIL arst_outputs got rdy=%0d vld=%0d data=%0d want 0 0 0", up_rdy, down_vld, down_data);
        else passed++;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            up_vld = 1;
            up_data = 9'd1;
            step();
        end
        up_vld = 0;
        total++;
        if (down_vld !== 1'b1 || down_data !== 11'd4)
            $display("FAIL arst_regroup got vld=%0d data=%0d want vld=1 data=4", down_vld, down_data);
        else passed++;
        step();
    endtask

`ifdef SUM_GROUP_EARLY_LAST_EN
    task automatic test_early_last();
        down_rdy = 1;
        up_vld = 1;
        up_data = 9'd3;
        step();
        up_data = 9'd5;
        up_last = 1;
        step();
        up_vld = 0;
        up_last = 0;
        total++;
        if (down_vld !== 1'b1 || down_data !== 11'd8)
            $display("FAIL early_short got vld=%0d data=%0d want vld=1 data=8", down_vld, down_data);
        else passed++;
        step();
        for (int i = 0; i < 4; i++) begin
            up_vld = 1;
            up_data = 9'd1;
            step();
        end
        up_vld = 0;
        total++;
        if (down_vld !== 1'b1 || down_data !== 11'd4)
            $display("FAIL early_full got vld=%0d data=%0d want vld=1 data=4", down_vld, down_data);
        else passed++;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
`ifdef SUM_GROUP_EARLY_LAST_EN
        test_early_last();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sum_group_accumulator.md
# sum_group_accumulator

Downstream consumer of the adder's sum stream: accepts the flow-controlled sum stream, accumulates a fixed-size group of consecutive sums, and emits one wider group total per group on its own valid/ready output. Sits directly after the sum output buffer of the adder and feeds the next flow-controlled stage or the pin-level output.

## Interface
- `in_width`, default 9: input data width; matches the adder sum width of 8 plus a carry bit.
- `n_items`, default 4: sums per group; at least 1.
- `out_width`, default `in_width + $clog2(n_items)`: output width; the full group total never overflows.
- `clk`  input  1  clock; all state on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `up_vld`  input  1  input sum valid.
- `up_rdy`  output  1  input sum ready.
- `up_data`  input  in_width  input sum, unsigned.
- `up_last`  input  1  early group end. Present only with `SUM_GROUP_EARLY_LAST_EN`.
- `down_vld`  output  1  group total valid.
- `down_rdy`  input  1  group total ready.
- `down_data`  output  out_width  group total, unsigned.

## Operation
- Input transfer: `up_vld & up_rdy` on a rising edge. Output transfer: `down_vld & down_rdy`.
- State machine `ACCUM` / `HOLD`. Registers are `acc` (out_width), `cnt` (`$clog2(n_items)+1` bits) and the output register.
- In `ACCUM`:
  - `up_rdy = 1` and `down_vld = 0`.
  - On an input transfer, `acc += zero-extended up_data` and `cnt++`.
  - When the transfer is the group's final item (`cnt == n_items-1`), load `acc + up_data` into the output register, clear `acc` and `cnt`, and go to `HOLD`.
- In `HOLD`:
  - `down_vld = 1` and `up_rdy = down_rdy`. This combinational path is the only one.
  - An output transfer with no input transfer returns to `ACCUM`.
  - An output transfer together with an input transfer (simultaneous events) starts the next group with `acc = up_data` and `cnt = 1`.
  - If `n_items == 1`, that input completes a group immediately. The output register reloads and the block stays in `HOLD`.
- `down_data` is stable while `down_vld & ~down_rdy`.
- Arithmetic is unsigned, with no truncation; `out_width` is always sufficient.
- `up_data` is ignored when `up_vld = 0`.

## Timing
- Reset values: state `ACCUM`, `acc = 0`, `cnt = 0`, `down_vld = 0`, `down_data = 0`.
- `up_rdy` is forced to 0 while `rst` is high, and equals 1 on the first edge after release.
- Latency: `down_vld` rises on the cycle after the final item's transfer.
- Throughput: one input per cycle sustained while `down_rdy = 1`. No bubbles between groups.
- Backpressure: with `down_rdy = 0` in `HOLD`, input stalls after exactly one complete group is buffered.
- Reset mid-group discards the partial `acc`/`cnt` and any held total. No output is produced for the discarded data.

## Configuration
- `SUM_GROUP_EARLY_LAST_EN` defined:
  - The `up_last` port exists.
  - An input transfer with `up_last = 1` closes the group regardless of `cnt`, so a short group is emitted.
  - `up_last` on the `n_items`-th item is equivalent to no `up_last`.
- `SUM_GROUP_EARLY_LAST_EN` undefined:
  - The port is absent and groups are always exactly `n_items` long.

## Structure
- Shared package `sum_group_pkg`:
  - `typedef enum logic [0:0] { ACCUM, HOLD } sum_group_state_t`.
  - Function computing the default `out_width` from `in_width` and `n_items`.
- One natural sub-module, `group_item_counter`:
  - Inputs: increment, restart-at-one, clear.
  - Output: final-item flag, which is `cnt == n_items-1` OR'd with `up_last` when enabled.
- The accumulator, output register and FSM stay in the top module.

## Test plan
- `n_items = 4`, inputs 1, 2, 3, 4 back-to-back with `down_rdy = 1` -> `down_data = 10`, `down_vld` high exactly one cycle after the 4th transfer.
- Inputs 511 ×4 (`in_width = 9`, `out_width = 11`) -> `down_data = 2044`, no overflow.
- Inputs 1..8 continuous with `down_rdy = 1` -> outputs 10 then 26, `up_rdy` never low, no gap cycle.
- `down_rdy = 0` after the first group -> `up_rdy = 0` while in `HOLD`, `down_data` stays 10. When `down_rdy` goes high, `up_rdy` follows in the same cycle and input 5 is accepted on that edge.
- Assert `rst` asynchronously after inputs 7, 7 -> all outputs return to reset values immediately. Then inputs 1, 1, 1, 1 -> output 4.
- With `SUM_GROUP_EARLY_LAST_EN`: inputs 3, 5 with `up_last` on 5 -> output 8. Next group 1, 1, 1, 1 -> output 4.
